// File: rtl/regfile_mp.sv
// Multi-port register file: N combinational read ports, a full-word write port (A),
// a byte-lane load-return write port (B), optional write bypass and a pending-load scoreboard.
module regfile_mp #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2,
   parameter int BYPASS = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
   output logic [NUM_RD*DATA_W-1:0]   rd_data_o,
   output logic [NUM_RD-1:0]          rd_busy_o,
   input  logic                       wa_en_i,
   input  logic [ADDR_W-1:0]          wa_addr_i,
   input  logic [DATA_W-1:0]          wa_data_i,
   input  logic                       wb_en_i,
   input  logic [ADDR_W-1:0]          wb_addr_i,
   input  logic [DATA_W-1:0]          wb_data_i,
   input  logic [DATA_W/8-1:0]        wb_be_i,
   input  logic                       pend_set_i,
   input  logic [ADDR_W-1:0]          pend_addr_i,
   output logic                       any_pending_o,
   output logic [DATA_W-1:0]          v0_o
);

   localparam int DEPTH = 2**ADDR_W;
   localparam int NB    = DATA_W/8;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [DEPTH-1:0]  pend_q, pend_d;
   logic              any_pending_q;

   // Port A writes the whole word first so that port B lanes land on top of it,
   // which gives the collision rule (B lanes win, A fills the rest) for free.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i]  = mem_q[i];
         pend_d[i] = pend_q[i];
         if (i != 0) begin
            if (wa_en_i && (wa_addr_i == ADDR_W'(i)))
               mem_d[i] = wa_data_i;
            if (wb_en_i && (wb_addr_i == ADDR_W'(i))) begin
               for (int b = 0; b < NB; b++)
                  if (wb_be_i[b])
                     mem_d[i][b*8 +: 8] = wb_data_i[b*8 +: 8];
               pend_d[i] = 1'b0;
            end
            if (pend_set_i && (pend_addr_i == ADDR_W'(i)))
               pend_d[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= '0;
         pend_q        <= '0;
         any_pending_q <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= mem_d[i];
         pend_q        <= pend_d;
         any_pending_q <= |pend_d;
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic              wb_clears;
      assign ra        = rd_addr_i[k*ADDR_W +: ADDR_W];
      // A load returning this cycle un-busies its register unless a new load re-targets it.
      assign wb_clears = (BYPASS != 0) && wb_en_i && (wb_addr_i == ra) &&
                         !(pend_set_i && (pend_addr_i == ra));
      assign rd_data_o[k*DATA_W +: DATA_W] = (ra == '0) ? '0 :
                                             ((BYPASS != 0) ? mem_d[ra] : mem_q[ra]);
      assign rd_busy_o[k] = (ra != '0) && pend_q[ra] && !wb_clears;
   end

   assign any_pending_o = any_pending_q;
   assign v0_o          = mem_q[2];

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp (default parameters, BYPASS=1): directed vector table,
// hand-written reset sequences and randomized traffic against an array model.
module tb_regfile_mp;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 2;
   localparam int DEPTH = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic [NR*AW-1:0] rd_addr;
   logic [NR*DW-1:0] rd_data;
   logic [NR-1:0]    rd_busy;
   logic            wa_en;
   logic [AW-1:0]   wa_addr;
   logic [DW-1:0]   wa_data;
   logic            wb_en;
   logic [AW-1:0]   wb_addr;
   logic [DW-1:0]   wb_data;
   logic [3:0]      wb_be;
   logic            pend_set;
   logic [AW-1:0]   pend_addr;
   logic            any_pending;
   logic [DW-1:0]   v0;

   int n_pass = 0;
   int n_total = 0;

   regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1)) dut (
      .clk          (clk),
      .rst          (rst),
      .rd_addr_i    (rd_addr),
      .rd_data_o    (rd_data),
      .rd_busy_o    (rd_busy),
      .wa_en_i      (wa_en),
      .wa_addr_i    (wa_addr),
      .wa_data_i    (wa_data),
      .wb_en_i      (wb_en),
      .wb_addr_i    (wb_addr),
      .wb_data_i    (wb_data),
      .wb_be_i      (wb_be),
      .pend_set_i   (pend_set),
      .pend_addr_i  (pend_addr),
      .any_pending_o(any_pending),
      .v0_o         (v0)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic idle_inputs();
      wa_en = 0; wa_addr = '0; wa_data = '0;
      wb_en = 0; wb_addr = '0; wb_data = '0; wb_be = '0;
      pend_set = 0; pend_addr = '0;
   endtask

   // ---------------- reference model ----------------
   logic [DW-1:0] m_reg [DEPTH];
   logic          m_pend [DEPTH];

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         m_reg[i] = '0;
         m_pend[i] = 1'b0;
      end
   endtask

   // Value register a will hold after this edge: B-enabled lanes from wb_data,
   // other lanes from wa_data if port A targets it, else the old contents.
   function automatic logic [DW-1:0] model_next(input int a);
      logic [DW-1:0] base, res;
      if (a == 0) return '0;
      base = (wa_en && wa_addr == a) ? wa_data : m_reg[a];
      res = base;
      if (wb_en && wb_addr == a)
         for (int l = 0; l < 4; l++)
            res[l*8 +: 8] = wb_be[l] ? wb_data[l*8 +: 8] : base[l*8 +: 8];
      return res;
   endfunction

   function automatic logic model_busy(input int a);
      if (a == 0) return 1'b0;
      if (wb_en && wb_addr == a && !(pend_set && pend_addr == a)) return 1'b0;
      return m_pend[a];
   endfunction

   function automatic logic model_any();
      logic r = 1'b0;
      for (int i = 0; i < DEPTH; i++) r = r | m_pend[i];
      return r;
   endfunction

   task automatic model_edge();
      logic [DW-1:0] nxt [DEPTH];
      for (int i = 0; i < DEPTH; i++) nxt[i] = model_next(i);
      for (int i = 0; i < DEPTH; i++) m_reg[i] = nxt[i];
      if (wb_en && wb_addr != 0) m_pend[wb_addr] = 1'b0;
      if (pend_set && pend_addr != 0) m_pend[pend_addr] = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1; idle_inputs();
      @(posedge clk);
      @(negedge clk);
      rst = 0;
      model_reset();
   endtask

   task automatic sweep_zero();
      for (int a = 0; a < DEPTH; a++) begin
         rd_addr = {AW'(a), AW'(DEPTH-1-a)};
         #1;
         check("sweep_rd0", rd_data[DW-1:0], '0);
         check("sweep_rd1", rd_data[2*DW-1:DW], '0);
         check("sweep_busy", DW'(rd_busy), '0);
      end
      check("sweep_v0", v0, '0);
      check("sweep_anyp", DW'(any_pending), '0);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic          wa_en;  logic [AW-1:0] wa_addr; logic [DW-1:0] wa_data;
      logic          wb_en;  logic [AW-1:0] wb_addr; logic [DW-1:0] wb_data; logic [3:0] wb_be;
      logic          ps;     logic [AW-1:0] pa;
      logic [AW-1:0] r0;     logic [AW-1:0] r1;
      logic [DW-1:0] e_rd0;  logic [DW-1:0] e_rd1; logic [1:0] e_busy;
      logic [DW-1:0] e_v0;   logic e_anyp;
   } vec_t;

   vec_t vecs [16];

   initial begin
      //            waen wa  wadata        wben wb  wbdata        be       ps pa  r0 r1  e_rd0         e_rd1         busy   v0 after      anyp
      vecs[0]  = '{1, 2,  32'hDEADBEEF, 0, 0,  32'h0,        4'b0000, 0, 0,  2, 0,  32'hDEADBEEF, 32'h0,        2'b00, 32'hDEADBEEF, 0};
      vecs[1]  = '{0, 0,  32'h0,        0, 0,  32'h0,        4'b0000, 0, 0,  2, 2,  32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 32'hDEADBEEF, 0};
      vecs[2]  = '{1, 5,  32'h11223344, 0, 0,  32'h0,        4'b0000, 0, 0,  5, 2,  32'h11223344, 32'hDEADBEEF, 2'b00, 32'hDEADBEEF, 0};
      vecs[3]  = '{0, 0,  32'h0,        1, 5,  32'hAABBCCDD, 4'b0101, 0, 0,  5, 5,  32'h11BB33DD, 32'h11BB33DD, 2'b00, 32'hDEADBEEF, 0};
      vecs[4]  = '{0, 0,  32'h0,        1, 5,  32'hFFFFFFFF, 4'b0000, 0, 0,  5, 5,  32'h11BB33DD, 32'h11BB33DD, 2'b00, 32'hDEADBEEF, 0};
      vecs[5]  = '{1, 7,  32'h12345678, 1, 7,  32'hAABBCCDD, 4'b1100, 0, 0,  7, 5,  32'hAABB5678, 32'h11BB33DD, 2'b00, 32'hDEADBEEF, 0};
      vecs[6]  = '{0, 0,  32'h0,        0, 0,  32'h0,        4'b0000, 0, 0,  7, 7,  32'hAABB5678, 32'hAABB5678, 2'b00, 32'hDEADBEEF, 0};
      vecs[7]  = '{0, 0,  32'h0,        0, 0,  32'h0,        4'b0000, 1, 9,  9, 7,  32'h0,        32'hAABB5678, 2'b00, 32'hDEADBEEF, 1};
      vecs[8]  = '{0, 0,  32'h0,        0, 0,  32'h0,        4'b0000, 0, 0,  9, 9,  32'h0,        32'h0,        2'b11, 32'hDEADBEEF, 1};
      vecs[9]  = '{0, 0,  32'h0,        1, 9,  32'h01020304, 4'b1111, 1, 9,  9, 9,  32'h01020304, 32'h01020304, 2'b11, 32'hDEADBEEF, 1};
      vecs[10] = '{0, 0,  32'h0,        1, 9,  32'hFFFFFFFF, 4'b0000, 0, 0,  9, 9,  32'h01020304, 32'h01020304, 2'b00, 32'hDEADBEEF, 0};
      vecs[11] = '{0, 0,  32'h0,        0, 0,  32'h0,        4'b0000, 0, 0,  9, 9,  32'h01020304, 32'h01020304, 2'b00, 32'hDEADBEEF, 0};
      vecs[12] = '{1, 0,  32'hFFFFFFFF, 1, 0,  32'hFFFFFFFF, 4'b1111, 1, 0,  0, 0,  32'h0,        32'h0,        2'b00, 32'hDEADBEEF, 0};
      vecs[13] = '{0, 0,  32'h0,        0, 0,  32'h0,        4'b0000, 0, 0,  0, 2,  32'h0,        32'hDEADBEEF, 2'b00, 32'hDEADBEEF, 0};
      vecs[14] = '{0, 0,  32'h0,        0, 0,  32'h0,        4'b0000, 1, 4,  4, 4,  32'h0,        32'h0,        2'b00, 32'hDEADBEEF, 1};
      vecs[15] = '{1, 4,  32'hCAFEF00D, 0, 0,  32'h0,        4'b0000, 0, 0,  4, 4,  32'hCAFEF00D, 32'hCAFEF00D, 2'b11, 32'hDEADBEEF, 1};
   end

   // ---------------- main sequence ----------------
   initial begin
      rst = 1; rd_addr = '0; idle_inputs();
      model_reset();
      do_reset();
      sweep_zero();

      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         wa_en = vecs[i].wa_en; wa_addr = vecs[i].wa_addr; wa_data = vecs[i].wa_data;
         wb_en = vecs[i].wb_en; wb_addr = vecs[i].wb_addr; wb_data = vecs[i].wb_data;
         wb_be = vecs[i].wb_be; pend_set = vecs[i].ps; pend_addr = vecs[i].pa;
         rd_addr = {vecs[i].r1, vecs[i].r0};
         #1;
         check($sformatf("vec%0d_rd0", i), rd_data[DW-1:0], vecs[i].e_rd0);
         check($sformatf("vec%0d_rd1", i), rd_data[2*DW-1:DW], vecs[i].e_rd1);
         check($sformatf("vec%0d_busy", i), DW'(rd_busy), DW'(vecs[i].e_busy));
         model_edge();
         @(posedge clk); #1;
         check($sformatf("vec%0d_v0", i), v0, vecs[i].e_v0);
         check($sformatf("vec%0d_anyp", i), DW'(any_pending), DW'(vecs[i].e_anyp));
      end

      // Randomized traffic; the model carries state over from the table (r4 still pending).
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         wa_en = 1'($urandom_range(0, 1)); wa_addr = AW'($urandom_range(0, 15)); wa_data = $urandom;
         wb_en = 1'($urandom_range(0, 1)); wb_addr = AW'($urandom_range(0, 15)); wb_data = $urandom;
         wb_be = 4'($urandom_range(0, 15));
         pend_set = ($urandom_range(0, 3) == 0); pend_addr = AW'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) wb_addr = wa_addr;
         if ($urandom_range(0, 3) == 0) pend_addr = wb_addr;
         rd_addr = {AW'($urandom_range(0, 15)), ($urandom_range(0, 1) != 0) ? wb_addr : AW'($urandom_range(0, 15))};
         #1;
         for (int k = 0; k < NR; k++) begin
            check($sformatf("rnd%0d_rd%0d", c, k), rd_data[k*DW +: DW], model_next(int'(rd_addr[k*AW +: AW])));
            check($sformatf("rnd%0d_busy%0d", c, k), DW'(rd_busy[k]), DW'(model_busy(int'(rd_addr[k*AW +: AW]))));
         end
         model_edge();
         @(posedge clk); #1;
         check($sformatf("rnd%0d_v0", c), v0, m_reg[2]);
         check($sformatf("rnd%0d_anyp", c), DW'(any_pending), DW'(model_any()));
      end

      // Reset wins over a same-cycle port A write, pend_set and port B write.
      @(negedge clk);
      wa_en = 1; wa_addr = 3; wa_data = 32'h55AA55AA;
      wb_en = 1; wb_addr = 2; wb_data = 32'h12121212; wb_be = 4'hF;
      pend_set = 1; pend_addr = 6;
      rst = 1;
      @(posedge clk);
      @(negedge clk);
      rst = 0; idle_inputs(); model_reset();
      rd_addr = {AW'(6), AW'(3)};
      #1;
      check("rstw_r3", rd_data[DW-1:0], '0);
      check("rstw_busy6", DW'(rd_busy[1]), '0);
      check("rstw_v0", v0, '0);
      check("rstw_anyp", DW'(any_pending), '0);
      sweep_zero();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the CPU general-purpose register file.
- Adds configurable data width and depth, N flattened read ports, and two independent write ports:
  - port A: ALU/PC result, full word.
  - port B: load return, any byte-enable pattern, lane-merged.
- Adds optional write-to-read bypass and a per-register pending-load scoreboard so the decode stage can stall on load-use hazards.
- Sits between decode (reads), execute (port A) and load/store unit (port B).

Parameters:
- DATA_W, 32, register width in bits; multiple of 8.
- ADDR_W, 5, register index width; depth = 2**ADDR_W.
- NUM_RD, 2, number of read ports.
- BYPASS, 1, 1 = reads return this cycle's write data; 0 = reads return stored value only.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_addr  in  NUM_RD*ADDR_W  read indices; port k at bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data; port k at bits [k*DATA_W +: DATA_W].
- rd_busy  out  NUM_RD  pending-load flag for each read port's register.
- wa_en  in  1  port A write enable.
- wa_addr  in  ADDR_W  port A destination index.
- wa_data  in  DATA_W  port A write data.
- wb_en  in  1  port B write enable.
- wb_addr  in  ADDR_W  port B destination index.
- wb_data  in  DATA_W  port B write data, lane-aligned.
- wb_be  in  DATA_W/8  port B byte enables.
- pend_set  in  1  load issued; mark pend_addr pending.
- pend_addr  in  ADDR_W  register targeted by the issued load.
- any_pending  out  1  registered OR of all pending bits.
- v0  out  DATA_W  stored content of register 2, debug/testbench observation.

Behaviour:
- Reset:
  - rst high at a clock edge clears all registers and all pending bits.
  - rst overrides any write or pend_set in the same cycle.
  - After reset: v0=0, any_pending=0; every rd_data=0 and rd_busy=0 unless bypass applies.
- Register 0:
  - Reads always return 0 and rd_busy=0.
  - Writes and pend_set to index 0 are ignored.
- Port A: when wa_en=1 and wa_addr!=0, the full word is written at the edge.
- Port B:
  - When wb_en=1 and wb_addr!=0, each byte lane i with wb_be[i]=1 is replaced by wb_data lane i; other lanes keep their value.
  - All 2**(DATA_W/8) patterns are legal, including non-contiguous ones.
  - wb_be=0 writes nothing but still clears the pending bit.
- Same-address collision (wa_addr==wb_addr, both enabled, nonzero):
  - Port B lanes with wb_be=1 take wb_data.
  - All remaining lanes take wa_data.
- Reads:
  - Combinational, no read latency.
  - BYPASS=1: if the read index matches an active write this cycle, rd_data returns the merged value that will be stored at the edge, applying the same collision rule. Otherwise it returns the stored value.
  - BYPASS=0: reads always return the stored value. Write data is visible one cycle after the edge.
- Scoreboard:
  - pend_set sets pending[pend_addr].
  - A port B write to an address (wb_en=1) clears its bit.
  - Same-cycle set and clear on the same address: set wins, since a new load has been issued.
  - Port A writes do not affect pending bits.
  - rd_busy[k] = pending[rd_addr k].
  - With BYPASS=1, rd_busy[k] is forced to 0 when port B writes that address this cycle and pend_set does not target it.
  - rd_busy is combinational; any_pending is derived from stored bits only.
- v0 reflects stored register 2 and never reflects bypassed data.
- Unknown/X inputs on a disabled write port have no effect.

Test Plan:
- Reset then read all 2**ADDR_W indices on both ports -> every rd_data=0, rd_busy=0, v0=0, any_pending=0.
- Port A write r2=0xDEADBEEF; same cycle read r2 -> BYPASS=1: rd_data=0xDEADBEEF immediately; BYPASS=0: 0 until next cycle. v0=0xDEADBEEF after the edge.
- Preload r5=0x11223344; port B write wb_data=0xAABBCCDD, wb_be=4'b0101 -> r5=0x11BB33DD. Repeat with wb_be=0 -> r5 unchanged.
- Same-cycle collision on r7: wa_data=0x12345678, wb_data=0xAABBCCDD, wb_be=4'b1100 -> r7=0xAABB5678.
- Scoreboard sequence:
  - pend_set r9 -> next cycle rd_busy=1 for r9 and any_pending=1.
  - Port B write r9 together with pend_set r9 -> r9 stays busy.
  - Port B write r9 alone -> busy clears and any_pending=0.
- Writes and pend_set to r0 with data 0xFFFFFFFF -> r0 reads 0, rd_busy=0. rst asserted while wa_en=1 to r3 -> r3=0 after the edge.
